// File: rtl/instruction_sequencer_if.sv
// Loader/decoder-facing signal bundle of the instruction sequencer.
// The master side drives opcodes and decoder flags; the slave side is the sequencer.
interface instruction_sequencer_if;
    logic       instructionRegReadEnable;
    logic [7:0] nextInstruction;
    logic       endInstruction;
    logic       skipCycle;
    logic [7:0] currentInstruction;
    logic [2:0] timeState;
    logic       loadNextInstruction;
    logic       jammed;
    logic [3:0] cycleCount;

    modport master (
        output instructionRegReadEnable, nextInstruction, endInstruction, skipCycle,
        input  currentInstruction, timeState, loadNextInstruction, jammed, cycleCount
    );

    modport slave (
        input  instructionRegReadEnable, nextInstruction, endInstruction, skipCycle,
        output currentInstruction, timeState, loadNextInstruction, jammed, cycleCount
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Instruction register plus T0..T6 timing-state sequencer with a JAM trap state.
// Registers only advance on edges where enableFFs and rdy are both high.
module instruction_sequencer #(
    parameter logic [2:0] JAM_STATE    = 3'd7,
    parameter logic [7:0] RESET_OPCODE = 8'h00
) (
    input  logic clk,
    input  logic nrst,
    input  logic enableFFs,
    input  logic rdy,
    instruction_sequencer_if.slave bus
);

    typedef enum logic [1:0] {BOOT, RUN, JAM} seq_state_t;

    seq_state_t state, state_next;
    logic [2:0] t_reg, t_next;
    logic [7:0] ir_reg, ir_next;
    logic [3:0] cc_reg, cc_next;
    logic [3:0] cc_inc;
    logic [3:0] t_sum;
    logic       update;

    assign update = enableFFs & rdy;
    assign cc_inc = (cc_reg == 4'd15) ? cc_reg : cc_reg + 4'd1;
    assign t_sum  = {1'b0, t_reg} + (bus.skipCycle ? 4'd2 : 4'd1);

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state  <= BOOT;
            t_reg  <= 3'd0;
            ir_reg <= RESET_OPCODE;
            cc_reg <= 4'd0;
        end else if (update) begin
            state  <= state_next;
            t_reg  <= t_next;
            ir_reg <= ir_next;
            cc_reg <= cc_next;
        end
    end

    // An IR load overrides everything, JAM included; otherwise end beats skip beats increment.
    always_comb begin
        state_next = state;
        t_next     = t_reg;
        ir_next    = ir_reg;
        cc_next    = cc_reg;
        if (bus.instructionRegReadEnable) begin
            state_next = RUN;
            t_next     = 3'd0;
            ir_next    = bus.nextInstruction;
            cc_next    = 4'd0;
        end else begin
            case (state)
                BOOT: begin
                    state_next = RUN;
                    t_next     = 3'd0;
                    cc_next    = 4'd0;
                end
                RUN: begin
                    if (bus.endInstruction) begin
                        t_next  = 3'd0;
                        cc_next = 4'd0;
                    end else begin
                        cc_next = cc_inc;
                        if (t_sum > 4'd6) begin
                            state_next = JAM;
                        end else begin
                            t_next = t_sum[2:0];
                        end
                    end
                end
                JAM: begin
                    cc_next = cc_inc;
                end
                default: begin
                    state_next = BOOT;
                    t_next     = 3'd0;
                    cc_next    = 4'd0;
                end
            endcase
        end
    end

    assign bus.currentInstruction  = ir_reg;
    assign bus.timeState           = (state == JAM) ? JAM_STATE : t_reg;
    assign bus.jammed              = (state == JAM);
    assign bus.cycleCount          = cc_reg;
    assign bus.loadNextInstruction = (bus.endInstruction && state == RUN) || (state == BOOT);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed stimulus with a queued scoreboard; a monitor process pops and compares
// each expectation when the stimulus signals that outputs have settled.
module tb_instruction_sequencer;

    typedef struct {
        string      name;
        logic [7:0] ir;
        logic [2:0] ts;
        logic [3:0] cc;
        logic       jam;
        logic       lni;
    } exp_t;

    logic clk;
    logic nrst;
    logic enableFFs;
    logic rdy;
    int   assertions;
    int   failures;
    exp_t exp_q[$];
    event check_ev;

    instruction_sequencer_if bus ();

    instruction_sequencer #(
        .JAM_STATE   (3'd7),
        .RESET_OPCODE(8'h00)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .enableFFs(enableFFs),
        .rdy      (rdy),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic expectNow(input string name, input logic [7:0] ir, input logic [2:0] ts,
                             input logic [3:0] cc, input logic jam, input logic lni);
        exp_t e;
        e.name = name; e.ir = ir; e.ts = ts; e.cc = cc; e.jam = jam; e.lni = lni;
        exp_q.push_back(e);
        ->check_ev;
        #1;
    endtask

    // Drive inputs, take one clock edge, then queue the expected settled outputs.
    task automatic applyStimulus(input logic ld, input logic [7:0] nxt, input logic endi,
                                 input logic skip, input logic r, input logic en,
                                 input string name, input logic [7:0] ir, input logic [2:0] ts,
                                 input logic [3:0] cc, input logic jam, input logic lni);
        bus.instructionRegReadEnable = ld;
        bus.nextInstruction          = nxt;
        bus.endInstruction           = endi;
        bus.skipCycle                = skip;
        rdy                          = r;
        enableFFs                    = en;
        @(posedge clk);
        #1;
        expectNow(name, ir, ts, cc, jam, lni);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        assertions++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    initial begin
        forever begin
            @(check_ev);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput({e.name, ".ir"},  bus.currentInstruction, e.ir);
                checkOutput({e.name, ".ts"},  {5'd0, bus.timeState}, {5'd0, e.ts});
                checkOutput({e.name, ".cc"},  {4'd0, bus.cycleCount}, {4'd0, e.cc});
                checkOutput({e.name, ".jam"}, {7'd0, bus.jammed}, {7'd0, e.jam});
                checkOutput({e.name, ".lni"}, {7'd0, bus.loadNextInstruction}, {7'd0, e.lni});
            end
        end
    end

    initial begin
        assertions = 0;
        failures   = 0;
        nrst       = 1'b1;
        enableFFs  = 1'b1;
        rdy        = 1'b1;
        bus.instructionRegReadEnable = 1'b0;
        bus.nextInstruction          = 8'h00;
        bus.endInstruction           = 1'b0;
        bus.skipCycle                = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expectNow("reset", 8'h00, 3'd0, 4'd0, 1'b0, 1'b1);
        nrst = 1'b0;

        // Load, step, end of instruction
        applyStimulus(1, 8'hA9, 0, 0, 1, 1, "loadA9", 8'hA9, 3'd0, 4'd0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 1, 1, "t1",     8'hA9, 3'd1, 4'd1, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 1, 1, "endT1",  8'hA9, 3'd0, 4'd0, 0, 1);

        // Run off the end of T6 into JAM; end is ignored there
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 8'h00, 0, 0, 1, 1, $sformatf("walk%0d", k), 8'hA9,
                          (k <= 6) ? 3'(k) : 3'd7, 4'(k), (k >= 7), 0);
        end
        applyStimulus(0, 8'h00, 1, 0, 1, 1, "jamEnd", 8'hA9, 3'd7, 4'd9, 1, 0);
        applyStimulus(1, 8'hEA, 0, 0, 1, 1, "loadEA", 8'hEA, 3'd0, 4'd0, 0, 0);

        // Skip behaviour
        applyStimulus(0, 8'h00, 0, 0, 1, 1, "s_t1",   8'hEA, 3'd1, 4'd1, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 1, 1, "s_t2",   8'hEA, 3'd2, 4'd2, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 1, 1, "skipT2", 8'hEA, 3'd4, 4'd3, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 1, 1, "s_t5",   8'hEA, 3'd5, 4'd4, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 1, 1, "skipT5", 8'hEA, 3'd7, 4'd5, 1, 0);
        applyStimulus(1, 8'hA9, 0, 0, 1, 1, "reload", 8'hA9, 3'd0, 4'd0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 8'h00, 0, 0, 1, 1, $sformatf("toT3_%0d", k), 8'hA9, 3'(k), 4'(k), 0, 0);
        end
        applyStimulus(0, 8'h00, 1, 1, 1, 1, "skipEnd", 8'hA9, 3'd0, 4'd0, 0, 1);

        // Stalls with end pending
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 8'h00, 0, 0, 1, 1, $sformatf("toT3b_%0d", k), 8'hA9, 3'(k), 4'(k), 0, 0);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 8'h00, 1, 0, 0, 1, $sformatf("rdyHold%0d", k), 8'hA9, 3'd3, 4'd3, 0, 1);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 8'h00, 1, 0, 1, 0, $sformatf("enHold%0d", k), 8'hA9, 3'd3, 4'd3, 0, 1);
        end
        applyStimulus(0, 8'h00, 1, 0, 1, 1, "endAfterStall", 8'hA9, 3'd0, 4'd0, 0, 1);

        // Asynchronous reset mid-instruction
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 8'h00, 0, 0, 1, 1, $sformatf("toT4_%0d", k), 8'hA9, 3'(k), 4'(k), 0, 0);
        end
        #1;
        nrst = 1'b1;
        #1;
        expectNow("asyncRst", 8'h00, 3'd0, 4'd0, 0, 1);
        @(negedge clk);
        nrst = 1'b0;

        // Saturation of cycleCount
        applyStimulus(1, 8'hA9, 0, 0, 1, 1, "satLoad", 8'hA9, 3'd0, 4'd0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(0, 8'h00, 0, 0, 1, 1, $sformatf("sat%0d", k), 8'hA9,
                          (k <= 6) ? 3'(k) : 3'd7, (k > 15) ? 4'd15 : 4'(k), (k >= 7), 0);
        end

        #20;
        assertions++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard drain: %0d left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
